// File: rtl/countup_pkg.sv
// Shared constants and helpers for the prescaled up/down counter.
package countup_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Width for a counter holding 0..n-1; never narrower than one bit so DIV=1 still elaborates.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: produces a registered one-cycle tick once every DIV clk cycles.
module tick_gen #(
  parameter int DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  import countup_pkg::*;

  localparam int               PRE_W    = clog2_min1(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_reg;
  logic             tick_reg;

  // Prescaler wraps at DIV-1; tick is registered so it lands the cycle after the wrap point.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (pre_reg == PRE_LAST);
      pre_reg  <= (pre_reg == PRE_LAST) ? '0 : pre_reg + PRE_W'(1);
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/countup_prescaled.sv
// Prescaled modulo up/down counter with load, terminal-count pulse and input synchronisers.
// Everything runs on clk; the prescaler only supplies a one-cycle enable.
module countup_prescaled #(
  parameter int WIDTH   = 6,
  parameter int MODULO  = 64,
  parameter int DIV     = 100000000,
  parameter int SYNC_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);
  import countup_pkg::*;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic             tick_w;
  logic [1:0]       pin_async;
  logic [1:0]       pin_s;
  logic             en_s;
  logic             dir_s;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             tc_reg;
  logic             tc_next;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_w)
  );

  // Bit 0 = enable switch, bit 1 = direction switch.
  assign pin_async = {up_dn, cnt_en};

  generate
    if (SYNC_EN != 0) begin : g_sync
      for (genvar gi = 0; gi < 2; gi++) begin : g_bit
        logic meta_reg;
        logic sync_reg;

        // Two-flop synchroniser for an asynchronous board switch.
        always_ff @(posedge clk) begin
          if (reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
          end else begin
            meta_reg <= pin_async[gi];
            sync_reg <= meta_reg;
          end
        end

        assign pin_s[gi] = sync_reg;
      end
    end else begin : g_nosync
      assign pin_s = pin_async;
    end
  endgenerate

  assign en_s  = pin_s[0];
  assign dir_s = pin_s[1];

  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

  // Next-state: load beats a step; a step only happens on an enabled tick; tc marks the wrap.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (load) begin
      count_next = load_clamped;
    end else if (tick_w && en_s) begin
      if (dir_s == DIR_UP) begin
        if (count_reg == MAX_VAL) begin
          count_next = '0;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else if (dir_s == DIR_DN) begin
        if (count_reg == '0) begin
          count_next = MAX_VAL;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg - WIDTH'(1);
        end
      end
    end
  end

  // Count and terminal-count registers; reset overrides any load or tick in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  assign count = count_reg;
  assign tick  = tick_w;
  assign tc    = tc_reg;

endmodule
